priority_queue_drain: RTL and testbench

- Consumer-side engine for the parameterized priority queue: issues dequeue pulses and captures the head entry, which the queue registers one cycle after each pulse.
- Presents captured entries downstream on a valid/ready stream through a small output FIFO.
- Credit-based flow control never over-pulls entries that cannot be buffered.
- Sits between the priority queue and any stream consumer (scheduler, packet egress).

---
 rtl/priority_queue_drain_if.sv | 42 ++++
 rtl/priority_queue_drain.sv | 140 ++++++++++++++
 tb/tb_priority_queue_drain.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/priority_queue_drain_if.sv
// Queue-side and stream-side handshake bundle for priority_queue_drain.
// master: drain engine (drives dequeue + stream); slave: queue/consumer.
interface priority_queue_drain_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRIORITY_WIDTH = 3
);

  // queue side
  logic                      o_q_dequeue;
  logic [DATA_WIDTH-1:0]     i_q_data;
  logic [PRIORITY_WIDTH-1:0] i_q_priority;
  logic                      i_q_empty;

  // downstream stream side
  logic                      o_valid;
  logic                      i_ready;
  logic [DATA_WIDTH-1:0]     o_data;
  logic [PRIORITY_WIDTH-1:0] o_priority;

  modport master (
    output o_q_dequeue,
    input  i_q_data,
    input  i_q_priority,
    input  i_q_empty,
    output o_valid,
    input  i_ready,
    output o_data,
    output o_priority
  );

  modport slave (
    input  o_q_dequeue,
    output i_q_data,
    output i_q_priority,
    output i_q_empty,
    input  o_valid,
    output i_ready,
    input  o_data,
    input  o_priority
  );

endinterface

// File: rtl/priority_queue_drain.sv
// Drain engine: pulls entries from a priority queue into a small FIFO
// and streams them downstream with credit-based over-pull protection.
// Ports: clk, rst_n (async low), i_enable, bus (queue + stream),
//   o_buf_count (FIFO occupancy), o_dispatched (accepted count),
//   o_busy (FSM active, capture pending or FIFO non-empty).
module priority_queue_drain #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRIORITY_WIDTH = 3,
  parameter int BUF_DEPTH      = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_enable,
  priority_queue_drain_if.master       bus,
  output logic [$clog2(BUF_DEPTH):0]   o_buf_count,
  output logic [CNT_WIDTH-1:0]         o_dispatched,
  output logic                         o_busy
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]                state_q;
  logic [1:0]                state_d;
  logic                      inflight_q;
  logic                      inflight_d;
  logic [AW-1:0]             wr_q;
  logic [AW-1:0]             wr_d;
  logic [AW-1:0]             rd_q;
  logic [AW-1:0]             rd_d;
  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_d;
  logic [CNT_WIDTH-1:0]      disp_q;
  logic [CNT_WIDTH-1:0]      disp_d;
  logic [DATA_WIDTH-1:0]     dat_q [BUF_DEPTH];
  logic [PRIORITY_WIDTH-1:0] pri_q [BUF_DEPTH];

  logic          push;
  logic          pop;
  logic          deq;
  logic          has_credit;
  logic [CW:0]   occ;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop  = (cnt_q != '0) & bus.i_ready;
  assign push = inflight_q;

  // Occupancy seen after this cycle's pop, counting the entry that the
  // queue is about to hand over; a new pull needs a free slot for it.
  assign occ = {1'b0, cnt_q}
             + {{CW{1'b0}}, inflight_q}
             - {{CW{1'b0}}, pop};

  assign has_credit = occ < (CW+1)'(BUF_DEPTH);

  assign deq = (state_q == S_RUN)
             & ~bus.i_q_empty
             & has_credit;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (i_enable) state_d = S_RUN;
      end
      (state_q == S_RUN): begin
        if (!i_enable) state_d = S_STOP;
      end
      (state_q == S_STOP): begin
        if (inflight_q && i_enable) begin
          state_d = S_RUN;
        end else if (!inflight_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = deq;
    wr_d       = push ? ptr_inc(wr_q) : wr_q;
    rd_d       = pop  ? ptr_inc(rd_q) : rd_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    disp_d     = disp_q + CNT_WIDTH'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      inflight_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
    end
  end

  // Storage is cleared too so the head reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        dat_q[i] <= '0;
        pri_q[i] <= '0;
      end
    end else if (push) begin
      dat_q[wr_q] <= bus.i_q_data;
      pri_q[wr_q] <= bus.i_q_priority;
    end
  end

  assign bus.o_q_dequeue = deq;
  assign bus.o_valid     = (cnt_q != '0);
  assign bus.o_data      = dat_q[rd_q];
  assign bus.o_priority  = pri_q[rd_q];

  assign o_buf_count  = cnt_q;
  assign o_dispatched = disp_q;
  assign o_busy       = (state_q != S_IDLE)
                      | inflight_q
                      | (cnt_q != '0);

endmodule

// File: tb/tb_priority_queue_drain.sv
// Bench for priority_queue_drain: behavioural queue + scoreboard.
// Directed scenarios followed by a randomized enable/ready/insert phase.
module tb_priority_queue_drain;

  localparam int DW   = 8;
  localparam int PW   = 3;
  localparam int BD   = 2;
  localparam int CNTW = 4;
  localparam int CW   = $clog2(BD) + 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [PW-1:0] p;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [CW-1:0]   buf_count;
  logic [CNTW-1:0] disp;
  logic            busy;

  priority_queue_drain_if #(
    .DATA_WIDTH(DW), .PRIORITY_WIDTH(PW)
  ) bus ();

  priority_queue_drain #(
    .DATA_WIDTH(DW), .PRIORITY_WIDTH(PW),
    .BUF_DEPTH(BD), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_enable(en),
    .bus(bus),
    .o_buf_count(buf_count),
    .o_dispatched(disp),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  ent_t ins[$];
  int   ins_rd = 0;
  ent_t pq[$];
  ent_t sb[$];
  int   sb_rd = 0;
  int   deq_cnt = 0;
  int   underflow = 0;

  int   mode_m = M_IDLE;
  bit   infl_m = 0;
  int   disp_m = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Priority queue: highest priority first, FIFO among equals.
  function automatic void pq_put(input ent_t e);
    int idx;
    idx = pq.size();
    for (int i = 0; i < pq.size(); i++) begin
      if (pq[i].p < e.p) begin
        idx = i;
        break;
      end
    end
    pq.insert(idx, e);
  endfunction

  // Queue model: registers the head one cycle after a dequeue pulse
  // and records it as the next expected stream entry.
  initial begin : driver
    logic seen;
    ent_t e;
    bus.i_q_empty    = 1'b1;
    bus.i_q_data     = '0;
    bus.i_q_priority = '0;
    forever begin
      @(negedge clk);
      seen = bus.o_q_dequeue;
      @(posedge clk);
      #1;
      if (seen) begin
        deq_cnt++;
        if (pq.size() == 0) begin
          underflow++;
        end else begin
          e = pq.pop_front();
          bus.i_q_data     = e.d;
          bus.i_q_priority = e.p;
          sb.push_back(e);
        end
      end
      while (ins_rd < ins.size()) begin
        pq_put(ins[ins_rd]);
        ins_rd++;
      end
      bus.i_q_empty = (pq.size() == 0);
    end
  end

  // Monitor: predicts stream/credit behaviour from counts of entries
  // pulled, held and accepted, and scores every presented entry.
  always @(negedge clk) begin : monitor
    int nbuf;
    bit expv;
    bit mpop;
    bit expdeq;
    bit expbusy;
    if (!rst_n) begin
      mode_m = M_IDLE;
      infl_m = 0;
      disp_m = 0;
      sb_rd  = sb.size();
    end else begin
      nbuf    = sb.size() - sb_rd - int'(infl_m);
      expv    = (nbuf > 0);
      mpop    = expv && bus.i_ready;
      expdeq  = (mode_m == M_RUN) && !bus.i_q_empty
             && (nbuf + int'(infl_m) - int'(mpop) < BD);
      expbusy = (mode_m != M_IDLE) || infl_m || expv;
      chk("valid", 32'(bus.o_valid), 32'(expv));
      chk("buf_count", 32'(buf_count), nbuf);
      chk("dequeue", 32'(bus.o_q_dequeue), 32'(expdeq));
      chk("busy", 32'(busy), 32'(expbusy));
      chk("dispatched", 32'(disp), disp_m);
      assert (!(dut.inflight_q && buf_count == CW'(BD)))
      else begin
        errors++;
        $display("FAIL push_full: count %0d at %0t",
                 buf_count, $time);
      end
      if (bus.o_valid && nbuf > 0) begin
        chk("data", 32'(bus.o_data), 32'(sb[sb_rd].d));
        chk("priority", 32'(bus.o_priority), 32'(sb[sb_rd].p));
      end
      if (bus.o_valid && bus.i_ready) begin
        chk("out_avail", 32'(nbuf > 0), 32'd1);
        if (nbuf > 0) sb_rd++;
      end
      if (mpop) disp_m = (disp_m + 1) % (1 << CNTW);
      case (mode_m)
        M_IDLE: if (en) mode_m = M_RUN;
        M_RUN:  if (!en) mode_m = M_STOP;
        default: begin
          if (infl_m && en) mode_m = M_RUN;
          else if (!infl_m) mode_m = M_IDLE;
        end
      endcase
      infl_m = expdeq;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic add(input int d, input int p);
    ent_t e;
    e.d = DW'(d);
    e.p = PW'(p);
    ins.push_back(e);
  endtask

  task automatic wait_drained(input string nm, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #3;
      if (ins.size() == ins_rd && pq.size() == 0
          && sb.size() == sb_rd) begin
        ok = 1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #3;
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_count", 32'(buf_count), 32'd0);
    chk("rst_disp", 32'(disp), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_deq", 32'(bus.o_q_dequeue), 32'd0);
    chk("rst_data", 32'(bus.o_data), 32'd0);
    chk("rst_prio", 32'(bus.o_priority), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int d0;
    int t0;
    bit ok;
    en          = 1'b0;
    bus.i_ready = 1'b0;
    rst_n       = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("init_valid", 32'(bus.o_valid), 32'd0);
    chk("init_count", 32'(buf_count), 32'd0);
    chk("init_disp", 32'(disp), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_deq", 32'(bus.o_q_dequeue), 32'd0);
    chk("init_data", 32'(bus.o_data), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // three entries, free-flowing
    d0 = deq_cnt;
    add('hC3, 2);
    add('hA1, 7);
    add('hB2, 5);
    cyc();
    bus.i_ready = 1'b1;
    en = 1'b1;
    wait_drained("t1_drain", 50);
    chk("t1_pulses", deq_cnt - d0, 3);
    chk("t1_disp", 32'(disp), 32'd3);
    en = 1'b0;
    repeat (3) cyc();
    chk("t1_busy", 32'(busy), 32'd0);

    // backpressure: only BD entries may be pulled
    d0 = deq_cnt;
    bus.i_ready = 1'b0;
    add('h11, 6);
    add('h22, 5);
    add('h33, 4);
    add('h44, 3);
    add('h55, 2);
    cyc();
    en = 1'b1;
    repeat (10) cyc();
    chk("t2_pulses", deq_cnt - d0, 2);
    chk("t2_count", 32'(buf_count), 32'd2);
    chk("t2_head", 32'(bus.o_data), 32'h11);
    bus.i_ready = 1'b1;
    wait_drained("t2_drain", 50);
    chk("t2_total", deq_cnt - d0, 5);
    chk("t2_disp", 32'(disp), 32'd8);
    en = 1'b0;
    wait_idle("t2_idle", 20);

    // drop enable right after a pulse
    for (int i = 0; i < 4; i++) add(i + 'h60, 3);
    repeat (2) cyc();
    d0 = deq_cnt;
    en = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #3;
      if (bus.o_q_dequeue) begin
        ok = 1;
        break;
      end
    end
    chk("t4_first_pulse", 32'(ok), 32'd1);
    cyc();
    en = 1'b0;
    wait_idle("t4_idle", 20);
    t0 = deq_cnt;
    repeat (5) cyc();
    chk("t4_pulses", deq_cnt - d0, 2);
    chk("t4_no_more", deq_cnt - t0, 0);
    chk("t4_delivered", sb.size() - sb_rd, 0);
    en = 1'b1;
    wait_drained("t4_drain", 50);
    en = 1'b0;
    wait_idle("t4_idle2", 20);

    // reset with a full FIFO
    bus.i_ready = 1'b0;
    for (int i = 0; i < 4; i++) add(i + 'h70, 4 - i);
    en = 1'b1;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (buf_count == CW'(BD)) begin
        ok = 1;
        break;
      end
    end
    chk("t5_full", 32'(ok), 32'd1);
    do_reset();
    bus.i_ready = 1'b1;
    wait_drained("t5_drain", 50);
    chk("t5_disp", 32'(disp), 32'd2);
    en = 1'b0;
    wait_idle("t5_idle", 20);

    // dispatched counter wrap
    do_reset();
    for (int i = 0; i < 17; i++) add($urandom, $urandom);
    en = 1'b1;
    wait_drained("t6_drain", 200);
    chk("t6_wrap", 32'(disp), 32'd1);

    // randomized phase
    for (int i = 0; i < 2000; i++) begin
      cyc();
      en          = ($urandom_range(0, 7) != 0);
      bus.i_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) add($urandom, $urandom);
    end
    cyc();
    en = 1'b1;
    bus.i_ready = 1'b1;
    wait_drained("rand_drain", 2000);
    en = 1'b0;
    wait_idle("rand_idle", 20);
    chk("underflow", underflow, 0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
